// File: rtl/chan_msg_arbiter.sv
// -----------------------------------------------------------------------------
// chan_msg_arbiter
//
// Shares one inter-CPU message bus toward the dispatcher among N_REQ channel
// controllers. One transaction is in flight at a time. Each transaction runs
// through four steps:
//   IDLE  - round-robin pick, latch the request, raise the grant
//   ISSUE - one-cycle strobe carrying the latched request
//   WAIT  - wait for a non-zero reply code from the dispatcher
//   DONE  - one-cycle reply valid to the granted requester, advance pointer
// The FSM only advances on edges where clk_oe=1. The strobe and the reply
// valid are cleared on every edge where clk_oe=0.
//
// Optional feature (macro CHAN_ARB_TIMEOUT_EN): WAIT gives up after TMO_CYC
// enabled edges without a reply. It then answers with NORES_CODE, the
// latched request address and zero data.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   clk_oe          phase enable
//   req_i           per-requester request level
//   req_msg_i       flattened request codes  (requester k at [k*MSG_W +: MSG_W])
//   req_addr_i      flattened request addresses
//   req_data_i      flattened request data
//   gnt_o           one-hot grant
//   resp_vld_o      one-hot, one-cycle reply valid
//   resp_msg_o      reply code (broadcast)
//   resp_addr_o     reply address (broadcast)
//   resp_data_o     reply data (broadcast)
//   bus_busy_i      dispatcher busy, blocks new grants
//   bus_strb_o      one-cycle issue strobe
//   bus_msg_o       issued code; 0 while the strobe is low
//   bus_addr_o      issued address; 0 while the strobe is low
//   bus_data_o      issued data; 0 while the strobe is low
//   bus_msg_i       dispatcher reply code; 0 means no reply
//   bus_addr_i      dispatcher reply address
//   bus_data_i      dispatcher reply data
// -----------------------------------------------------------------------------
module chan_msg_arbiter #(
    parameter int                N_REQ      = 4,
    parameter int                MSG_W      = 8,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                TMO_CYC    = 255,
    parameter logic [MSG_W-1:0]  NORES_CODE = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_oe,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*MSG_W-1:0]    req_msg_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          resp_vld_o,
    output logic [MSG_W-1:0]          resp_msg_o,
    output logic [ADDR_W-1:0]         resp_addr_o,
    output logic [DATA_W-1:0]         resp_data_o,
    input  logic                      bus_busy_i,
    output logic                      bus_strb_o,
    output logic [MSG_W-1:0]          bus_msg_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [DATA_W-1:0]         bus_data_o,
    input  logic [MSG_W-1:0]          bus_msg_i,
    input  logic [ADDR_W-1:0]         bus_addr_i,
    input  logic [DATA_W-1:0]         bus_data_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]    N_REQ_L  = (PTR_W + 1)'(N_REQ);
    localparam logic [N_REQ-1:0]  GNT_LSB  = {{(N_REQ - 1){1'b0}}, 1'b1};
    localparam logic [MSG_W-1:0]  ZERO_MSG  = {MSG_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    // Stop elaboration on a parameter set the design does not support.
    if (N_REQ < 2 || N_REQ > 8 || TMO_CYC < 1 || $bits(NORES_CODE) != MSG_W) begin : g_cfg_check
        $error("chan_msg_arbiter: unsupported parameter set");
    end

`ifdef CHAN_ARB_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_nxt_s;
`endif

    logic [1:0]          state_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    gidx_r;
    logic [N_REQ-1:0]    gnt_r;
    logic [MSG_W-1:0]    lat_msg_r;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [DATA_W-1:0]   lat_data_r;
    logic                bus_strb_r;
    logic [MSG_W-1:0]    bus_msg_r;
    logic [ADDR_W-1:0]   bus_addr_r;
    logic [DATA_W-1:0]   bus_data_r;
    logic [MSG_W-1:0]    rpl_msg_r;
    logic [ADDR_W-1:0]   rpl_addr_r;
    logic [DATA_W-1:0]   rpl_data_r;
    logic [N_REQ-1:0]    resp_vld_r;
    logic [MSG_W-1:0]    resp_msg_r;
    logic [ADDR_W-1:0]   resp_addr_r;
    logic [DATA_W-1:0]   resp_data_r;

    logic [2*N_REQ-1:0]  req_dbl_s;
    logic [N_REQ-1:0]    req_rot_s;
    logic [PTR_W-1:0]    off_s;
    logic [PTR_W:0]      sum_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic                pick_vld_s;
    logic [N_REQ-1:0]    pick_gnt_s;
    logic [MSG_W-1:0]    sel_msg_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [PTR_W-1:0]    nxt_ptr_s;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr.
    // This turns the round-robin search into a plain lowest-bit-first search.
    assign req_dbl_s = {req_i, req_i};
    assign req_rot_s = N_REQ'(req_dbl_s >> rr_ptr_r);
    assign pick_vld_s = |req_i;

    // Lowest set bit of the rotated vector. A descending scan lets the last hit win.
    always_comb begin
        off_s = {PTR_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = req_rot_s[i] ? PTR_W'(i) : off_s;
        end
    end

    // Undo the rotation: winner = (rr_ptr + offset) mod N_REQ.
    always_comb begin
        sum_s      = {1'b0, rr_ptr_r} + {1'b0, off_s};
        pick_idx_s = (sum_s >= N_REQ_L) ? PTR_W'(sum_s - N_REQ_L) : PTR_W'(sum_s);
        pick_gnt_s = GNT_LSB << pick_idx_s;
    end

    // Mux out the winning requester's message, address and data.
    always_comb begin
        sel_msg_s  = ZERO_MSG;
        sel_addr_s = ZERO_ADDR;
        sel_data_s = ZERO_DATA;
        for (int k = 0; k < N_REQ; k++) begin
            sel_msg_s  = (pick_idx_s == PTR_W'(k)) ? req_msg_i[k*MSG_W +: MSG_W]    : sel_msg_s;
            sel_addr_s = (pick_idx_s == PTR_W'(k)) ? req_addr_i[k*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_data_s = (pick_idx_s == PTR_W'(k)) ? req_data_i[k*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // After a completed transaction, the pointer moves one past the granted requester.
    assign nxt_ptr_s = (gidx_r == LAST_IDX) ? {PTR_W{1'b0}} : gidx_r + PTR_W'(1'b1);

`ifdef CHAN_ARB_TIMEOUT_EN
    assign tmo_nxt_s = tmo_cnt_r + TMO_W'(1'b1);
`endif

    // Transaction FSM with its latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {PTR_W{1'b0}};
            gidx_r      <= {PTR_W{1'b0}};
            gnt_r       <= {N_REQ{1'b0}};
            lat_msg_r   <= ZERO_MSG;
            lat_addr_r  <= ZERO_ADDR;
            lat_data_r  <= ZERO_DATA;
            bus_strb_r  <= 1'b0;
            bus_msg_r   <= ZERO_MSG;
            bus_addr_r  <= ZERO_ADDR;
            bus_data_r  <= ZERO_DATA;
            rpl_msg_r   <= ZERO_MSG;
            rpl_addr_r  <= ZERO_ADDR;
            rpl_data_r  <= ZERO_DATA;
            resp_vld_r  <= {N_REQ{1'b0}};
            resp_msg_r  <= ZERO_MSG;
            resp_addr_r <= ZERO_ADDR;
            resp_data_r <= ZERO_DATA;
`ifdef CHAN_ARB_TIMEOUT_EN
            tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
        end else if (!clk_oe) begin
            // Disabled phase: everything holds except the two one-cycle pulses.
            bus_strb_r <= 1'b0;
            bus_msg_r  <= ZERO_MSG;
            bus_addr_r <= ZERO_ADDR;
            bus_data_r <= ZERO_DATA;
            resp_vld_r <= {N_REQ{1'b0}};
        end else begin
            // Pulses default low and are raised only by the state that owns them.
            bus_strb_r <= 1'b0;
            bus_msg_r  <= ZERO_MSG;
            bus_addr_r <= ZERO_ADDR;
            bus_data_r <= ZERO_DATA;
            resp_vld_r <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!bus_busy_i && pick_vld_s) begin
                        gnt_r      <= pick_gnt_s;
                        gidx_r     <= pick_idx_s;
                        lat_msg_r  <= sel_msg_s;
                        lat_addr_r <= sel_addr_s;
                        lat_data_r <= sel_data_s;
                        state_r    <= ST_ISSUE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Any reply code seen on this edge is ignored; it cannot belong to this request.
                    bus_strb_r <= 1'b1;
                    bus_msg_r  <= lat_msg_r;
                    bus_addr_r <= lat_addr_r;
                    bus_data_r <= lat_data_r;
`ifdef CHAN_ARB_TIMEOUT_EN
                    tmo_cnt_r  <= {TMO_W{1'b0}};
`endif
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real reply wins over a timeout on the same edge.
                    if (bus_msg_i != ZERO_MSG) begin
                        rpl_msg_r  <= bus_msg_i;
                        rpl_addr_r <= bus_addr_i;
                        rpl_data_r <= bus_data_i;
                        state_r    <= ST_DONE;
`ifdef CHAN_ARB_TIMEOUT_EN
                    end else if (tmo_nxt_s == TMO_LIM) begin
                        rpl_msg_r  <= NORES_CODE;
                        rpl_addr_r <= lat_addr_r;
                        rpl_data_r <= ZERO_DATA;
                        state_r    <= ST_DONE;
                    end else begin
                        tmo_cnt_r  <= tmo_nxt_s;
                        state_r    <= ST_WAIT;
`else
                    end else begin
                        state_r    <= ST_WAIT;
`endif
                    end
                end
                ST_DONE: begin
                    // Reply fields change together with the valid pulse and then hold.
                    resp_vld_r  <= gnt_r;
                    resp_msg_r  <= rpl_msg_r;
                    resp_addr_r <= rpl_addr_r;
                    resp_data_r <= rpl_data_r;
                    gnt_r       <= {N_REQ{1'b0}};
                    rr_ptr_r    <= nxt_ptr_s;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= {N_REQ{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_r;
    assign resp_vld_o  = resp_vld_r;
    assign resp_msg_o  = resp_msg_r;
    assign resp_addr_o = resp_addr_r;
    assign resp_data_o = resp_data_r;
    assign bus_strb_o  = bus_strb_r;
    assign bus_msg_o   = bus_msg_r;
    assign bus_addr_o  = bus_addr_r;
    assign bus_data_o  = bus_data_r;

endmodule

// File: tb/tb_chan_msg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_chan_msg_arbiter
//
// Scoreboard bench for chan_msg_arbiter (N_REQ=4, 8-bit codes, 32-bit
// address/data). Each transaction pushes its expected strobe and its expected
// reply. A negedge monitor pops and compares these entries whenever the DUT
// raises bus_strb_o or resp_vld_o. A pulse with nothing queued counts as an
// error. When CHAN_ARB_TIMEOUT_EN is defined, the DUT is built with
// TMO_CYC=4 and the no-reply case is exercised as well.
// -----------------------------------------------------------------------------
module tb_chan_msg_arbiter;

    localparam int N = 4;
`ifdef CHAN_ARB_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    typedef struct {
        logic [3:0]  oh;
        logic [7:0]  msg;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_oe;
    logic [N-1:0]    req_i;
    logic [N*8-1:0]  req_msg_i;
    logic [N*32-1:0] req_addr_i;
    logic [N*32-1:0] req_data_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    resp_vld_o;
    logic [7:0]      resp_msg_o;
    logic [31:0]     resp_addr_o;
    logic [31:0]     resp_data_o;
    logic            bus_busy_i;
    logic            bus_strb_o;
    logic [7:0]      bus_msg_o;
    logic [31:0]     bus_addr_o;
    logic [31:0]     bus_data_o;
    logic [7:0]      bus_msg_i;
    logic [31:0]     bus_addr_i;
    logic [31:0]     bus_data_i;

    exp_t        strb_q[$];
    exp_t        resp_q[$];
    exp_t        mon_e;
    logic [7:0]  f_msg[N];
    logic [31:0] f_addr[N];
    logic [31:0] f_data[N];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        oe_tog = 1'b0;

    always #5 clk = ~clk;

    chan_msg_arbiter #(
        .N_REQ(N), .MSG_W(8), .DATA_W(32), .ADDR_W(32),
        .TMO_CYC(TB_TMO), .NORES_CODE(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe),
        .req_i(req_i), .req_msg_i(req_msg_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .gnt_o(gnt_o), .resp_vld_o(resp_vld_o), .resp_msg_o(resp_msg_o),
        .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o),
        .bus_busy_i(bus_busy_i), .bus_strb_o(bus_strb_o), .bus_msg_o(bus_msg_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_msg_i(bus_msg_i), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input logic [7:0] m, input logic [31:0] a, input logic [31:0] d);
        f_msg[k] = m;
        f_addr[k] = a;
        f_data[k] = d;
        req_msg_i[k*8 +: 8]   = m;
        req_addr_i[k*32 +: 32] = a;
        req_data_i[k*32 +: 32] = d;
    endtask

    task automatic push_strb(input int k);
        exp_t e;
        e.oh = 4'b0001 << k;
        e.msg = f_msg[k];
        e.addr = f_addr[k];
        e.data = f_data[k];
        strb_q.push_back(e);
    endtask

    task automatic push_resp(input int k, input logic [7:0] rm, input logic [31:0] ra, input logic [31:0] rd);
        exp_t e;
        e.oh = 4'b0001 << k;
        e.msg = rm;
        e.addr = ra;
        e.data = rd;
        resp_q.push_back(e);
    endtask

    // Dispatcher model: waits for the strobe, replies dly negedges later and
    // holds the reply until resp_vld. lat counts negedges from strobe to resp_vld.
    task automatic serve(input logic [7:0] rm, input logic [31:0] ra, input logic [31:0] rd,
                         input int dly, output int lat);
        int n;
        n = 0;
        lat = 0;
        @(negedge clk);
        while (bus_strb_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_val("strb_wait", 64'(bus_strb_o), 64'd1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            lat++;
        end
        bus_msg_i = rm;
        bus_addr_i = ra;
        bus_data_i = rd;
        n = 0;
        do begin
            @(negedge clk);
            lat++;
            n++;
        end while (resp_vld_o == 4'b0000 && n < 300);
        if (n >= 300) check_val("resp_wait", 64'(resp_vld_o), 64'hF);
        bus_msg_i = 8'h00;
        bus_addr_i = 32'h0;
        bus_data_i = 32'h0;
    endtask

    // Scoreboard monitor: every strobe and reply pulse must match the next queued entry.
    always @(negedge clk) begin
        if (bus_strb_o) begin
            if (strb_q.size() > 0) begin
                mon_e = strb_q.pop_front();
                check_val("strb_gnt",  64'(gnt_o),      64'(mon_e.oh));
                check_val("strb_msg",  64'(bus_msg_o),  64'(mon_e.msg));
                check_val("strb_addr", 64'(bus_addr_o), 64'(mon_e.addr));
                check_val("strb_data", 64'(bus_data_o), 64'(mon_e.data));
            end else begin
                check_val("strb_unexp", 64'(bus_strb_o), 64'd0);
            end
        end else begin
            check_val("bus_idle_zero", 64'(|{bus_msg_o, bus_addr_o, bus_data_o}), 64'd0);
        end
        if (resp_vld_o != 4'b0000) begin
            if (resp_q.size() > 0) begin
                mon_e = resp_q.pop_front();
                check_val("resp_vld",  64'(resp_vld_o),  64'(mon_e.oh));
                check_val("resp_msg",  64'(resp_msg_o),  64'(mon_e.msg));
                check_val("resp_addr", 64'(resp_addr_o), 64'(mon_e.addr));
                check_val("resp_data", 64'(resp_data_o), 64'(mon_e.data));
            end else begin
                check_val("resp_unexp", 64'(resp_vld_o), 64'd0);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int lat;
        rst = 1'b1;
        clk_oe = 1'b1;
        req_i = 4'b0000;
        req_msg_i = '0;
        req_addr_i = '0;
        req_data_i = '0;
        bus_busy_i = 1'b0;
        bus_msg_i = 8'h00;
        bus_addr_i = 32'h0;
        bus_data_i = 32'h0;
        for (int k = 0; k < N; k++) set_req(k, 8'h10 + 8'(k), 32'h1000 + 32'(k * 16), 32'hD000 + 32'(k));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_gnt", 64'(gnt_o), 64'd0);
        check_val("reset_out", 64'(|{resp_vld_o, bus_strb_o, bus_msg_o, bus_addr_o, bus_data_o,
                                     resp_msg_o, resp_addr_o, resp_data_o}), 64'd0);
        rst = 1'b0;

        // Fairness from reset: all four requesting gives order 0,1,2,3,0.
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push_strb(i % 4);
            push_resp(i % 4, 8'h40 + 8'(i), 32'h2000 + 32'(i), 32'hC0DE0000 + 32'(i));
            serve(8'h40 + 8'(i), 32'h2000 + 32'(i), 32'hC0DE0000 + 32'(i), i % 3, lat);
        end
        req_i = 4'b0000;

        // Single request from requester 1, reply two cycles after the strobe.
        set_req(1, 8'h21, 32'h100, 32'hAB);
        req_i = 4'b0010;
        push_strb(1);
        push_resp(1, 8'h23, 32'h100, 32'h55);
        serve(8'h23, 32'h100, 32'h55, 2, lat);
        check_val("single_lat", 64'(lat), 64'd4);
        req_i = 4'b0000;

        // Pointer is now 2: 0111 must pick 2. A bogus reply during ISSUE is ignored.
        @(posedge clk);
        #1;
        set_req(2, 8'h31, 32'h300, 32'h3A);
        req_i = 4'b0111;
        bus_msg_i = 8'hEE;
        bus_addr_i = 32'hDEAD;
        bus_data_i = 32'hBEEF;
        push_strb(2);
        push_resp(2, 8'h33, 32'h333, 32'h66);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_msg_i = 8'h00;
        serve(8'h33, 32'h333, 32'h66, 0, lat);
        check_val("min_lat", 64'(lat), 64'd2);
        req_i = 4'b0000;

        // Busy dispatcher blocks the grant; release gives a grant on the next edge.
        @(posedge clk);
        #1;
        bus_busy_i = 1'b1;
        req_i = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        check_val("busy_no_gnt", 64'(gnt_o), 64'd0);
        bus_busy_i = 1'b0;
        push_strb(0);
        push_resp(0, 8'h51, 32'h500, 32'h5);
        @(posedge clk);
        @(negedge clk);
        check_val("busy_release_gnt", 64'(gnt_o), 64'b0001);
        serve(8'h51, 32'h500, 32'h5, 1, lat);
        req_i = 4'b0000;

        // clk_oe toggling every cycle: pointer 1 with 1001 picks 3, then 0011 picks 0.
        req_i = 4'b1001;
        push_strb(3);
        push_resp(3, 8'h61, 32'h600, 32'h6);
        oe_tog = 1'b1;
        fork
            begin
                while (oe_tog) begin
                    @(posedge clk);
                    #1 clk_oe = ~clk_oe;
                end
                clk_oe = 1'b1;
            end
        join_none
        serve(8'h61, 32'h600, 32'h6, 1, lat);
        req_i = 4'b0011;
        push_strb(0);
        push_resp(0, 8'h62, 32'h620, 32'h62);
        serve(8'h62, 32'h620, 32'h62, 0, lat);
        req_i = 4'b0000;
        oe_tog = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset in WAIT drops the transaction; a late reply is ignored.
        req_i = 4'b0100;
        push_strb(2);
        lat = 0;
        @(negedge clk);
        while (bus_strb_o !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) check_val("rst_strb_wait", 64'(bus_strb_o), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_i = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_wait_gnt", 64'(gnt_o), 64'd0);
        check_val("rst_wait_out", 64'(|{resp_vld_o, bus_strb_o, bus_msg_o, bus_addr_o, bus_data_o,
                                        resp_msg_o, resp_addr_o, resp_data_o}), 64'd0);
        rst = 1'b0;
        bus_msg_i = 8'h77;
        bus_addr_i = 32'h777;
        bus_data_i = 32'h7;
        repeat (4) @(negedge clk);
        bus_msg_i = 8'h00;
        bus_addr_i = 32'h0;
        bus_data_i = 32'h0;
        check_val("late_reply_gnt", 64'(gnt_o), 64'd0);
        // Pointer back at 0: 1001 picks 0 (a stale pointer of 1 would pick 3).
        req_i = 4'b1001;
        push_strb(0);
        push_resp(0, 8'h81, 32'h800, 32'h8);
        serve(8'h81, 32'h800, 32'h8, 1, lat);
        req_i = 4'b0000;

        // Requester drops req after grant: reply still delivered, pointer still advances.
        @(posedge clk);
        #1;
        req_i = 4'b0100;
        push_strb(2);
        push_resp(2, 8'h91, 32'h900, 32'h9);
        @(posedge clk);
        #1;
        req_i = 4'b0000;
        serve(8'h91, 32'h900, 32'h9, 1, lat);
        // Pointer now 3: 0101 picks 0 (a pointer left at 1 would pick 2).
        req_i = 4'b0101;
        push_strb(0);
        push_resp(0, 8'hA1, 32'hA00, 32'hA);
        serve(8'hA1, 32'hA00, 32'hA, 0, lat);
        req_i = 4'b0000;

`ifdef CHAN_ARB_TIMEOUT_EN
        // No reply: after 4 WAIT edges the DUT answers NORES with the address echoed.
        set_req(0, 8'hB1, 32'hB00, 32'hBB);
        req_i = 4'b0001;
        push_strb(0);
        push_resp(0, 8'h00, 32'hB00, 32'h0);
        serve(8'h00, 32'h0, 32'h0, 0, lat);
        check_val("tmo_lat", 64'(lat), 64'd5);
        req_i = 4'b0000;
`endif

        repeat (4) @(negedge clk);
        check_val("strb_q_empty", 64'(strb_q.size()), 64'd0);
        check_val("resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/chan_msg_arbiter.md
Name: chan_msg_arbiter

Overview:
- Shares one inter-CPU message bus (msg/addr/data toward the dispatcher) among N_REQ channel controllers.
- Round-robin grant per transaction: latch request, issue a one-cycle strobe, wait for a non-zero reply, route the reply back to the granted requester only.
- Sits between per-core channel controllers and the dispatcher message port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MSG_W, 8, message code width.
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- TMO_CYC, 255, wait-cycle limit; used only with TIMEOUT_EN.
- NORES_CODE, 8'h00, reply code synthesized on timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clk_oe  in  1  phase enable; the FSM advances only when 1
- req_i  in  N_REQ  per-requester request, level, held until resp_vld_o
- req_msg_i  in  N_REQ*MSG_W  flattened request codes; requester k at [k*MSG_W +: MSG_W]
- req_addr_i  in  N_REQ*ADDR_W  flattened request addresses
- req_data_i  in  N_REQ*DATA_W  flattened request data
- gnt_o  out  N_REQ  one-hot grant
- resp_vld_o  out  N_REQ  one-hot, one-cycle reply valid
- resp_msg_o  out  MSG_W  reply code (broadcast)
- resp_addr_o  out  ADDR_W  reply address
- resp_data_o  out  DATA_W  reply data
- bus_busy_i  in  1  dispatcher busy; blocks new grants
- bus_strb_o  out  1  one-cycle issue strobe
- bus_msg_o  out  MSG_W  issued code; 0 when bus_strb_o=0
- bus_addr_o  out  ADDR_W  issued address; 0 when bus_strb_o=0
- bus_data_o  out  DATA_W  issued data; 0 when bus_strb_o=0
- bus_msg_i  in  MSG_W  dispatcher reply; 0 means no reply
- bus_addr_i  in  ADDR_W  reply address
- bus_data_i  in  DATA_W  reply data

Behaviour:
- All state changes at posedge clk. rst=1 overrides clk_oe.
- Reset: state=IDLE, rr_ptr=0, and all outputs and latches 0.
- clk_oe=0: state, latches, rr_ptr and gnt_o hold; bus_strb_o and resp_vld_o are cleared to 0.
- IDLE:
  - Acts when bus_busy_i=0 and req_i!=0.
  - Picks the first set bit at index rr_ptr, rr_ptr+1, … mod N_REQ.
  - Latches that requester's msg/addr/data, sets gnt_o one-hot, and goes to ISSUE.
  - If bus_busy_i=1, stays in IDLE with no grant.
- ISSUE: bus_strb_o=1 for exactly one cycle; bus_* carry the latched values; go to WAIT.
- WAIT:
  - bus_msg_i sampled every enabled edge.
  - If non-zero: latch bus_msg_i/addr/data into resp_* and go to DONE.
  - A reply present in the same cycle as the strobe is ignored; the first eligible sample is the edge after the strobe.
- DONE:
  - resp_vld_o = gnt_o for one cycle; resp_* stay stable until the next DONE.
  - gnt_o cleared; rr_ptr = granted index + 1, wrapping N_REQ-1 to 0.
  - Return to IDLE.
- Requester dropping req_i after grant: the transaction is not aborted; the reply is still delivered and the pointer still advances.
- Latency with clk_oe=1 continuously:
  - req sampled at edge 0 → gnt at edge 0 → strobe high after edge 1.
  - Reply sampled at edge n≥2 → resp_vld high after edge n+1.
  - Minimum request-to-resp_vld: 3 edges.
- Only one transaction is outstanding at a time; no pipelining.
- rst mid-transaction drops the transaction silently; no resp_vld is issued.

Optional Feature:
- Macro: CHAN_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TMO_CYC+1) resets on entry to WAIT and increments on each enabled WAIT edge with no reply.
  - On reaching TMO_CYC, the FSM goes to DONE with resp_msg_o=NORES_CODE, resp_addr_o=latched request address, resp_data_o=0.
  - A real reply on the same edge wins over the timeout.
- When not defined: WAIT waits indefinitely and the counter is absent.

Test Plan:
- Single request: req_i=4'b0010, msg=8'h21, addr=0x100, data=0xAB; dispatcher replies 8'h23/0x100/0x55 two cycles after the strobe → one strobe carrying 21/100/AB, resp_vld_o=4'b0010 with 23/100/55, rr_ptr=2.
- Fairness: req_i=4'b1111 held for 4 transactions starting from reset → grant order 0,1,2,3, then 0 again.
- bus_busy_i=1 with req_i=4'b0001 for 5 cycles → no grant, no strobe; release busy → grant on the next edge.
- clk_oe toggling 1/0 every cycle during a transaction → same results as the continuous case; strobe and resp_vld each high for exactly one clk_oe=1 cycle.
- rst asserted in WAIT → all outputs 0 on the next edge; a later reply is ignored; a new request proceeds normally from rr_ptr=0.
- With CHAN_ARB_TIMEOUT_EN and TMO_CYC=4, no reply → resp_vld after 4 WAIT edges with NORES_CODE, addr echoed, data 0.
